// File: rtl/pulse_gen_ctrl_if.sv
// UART link and pulse outputs of the pulse generator, bundled for the controller port.
interface pulse_gen_ctrl_if;
    logic RS232_Rx;
    logic RS232_Tx;
    logic Pulse;
    logic Sync;
    logic P2;

    modport master (output RS232_Rx, input RS232_Tx, input Pulse, input Sync, input P2);
    modport slave  (input RS232_Rx, output RS232_Tx, output Pulse, output Sync, output P2);
endinterface

// File: rtl/pulse_gen_ctrl.sv
// Two-channel pulse timing engine programmed over an 8N1 UART link with 5-byte write
// frames (addr + 32-bit little-endian value); every complete frame is acknowledged on Tx.
module pulse_gen_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEF_PERIOD   = 60000,
    parameter int unsigned DEF_P1_W     = 30,
    parameter int unsigned DEF_DELAY    = 300,
    parameter int unsigned DEF_P2_W     = 60,
    parameter int unsigned SYNC_W       = 8
) (
    input logic             clk,
    input logic             resetn,
    pulse_gen_ctrl_if.slave bus
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] GAP_MAX   = 32'(2 * 10 * CLKS_PER_BIT);
    localparam logic [31:0] SYNC_LIM  = 32'(SYNC_W);

    logic [31:0] cnt, period, p1_w, delay, p2_w;
    logic [31:0] sh_period, sh_p1_w, sh_delay, sh_p2_w;
    logic        run;
    logic [31:0] period_eff;
    logic        wrap;
    logic [33:0] cnt_x, p2_start, p2_end;

    assign period_eff = (period < 32'd2) ? 32'd2 : period;
    assign wrap       = (cnt >= period_eff - 32'd1);
    assign cnt_x      = {2'b00, cnt};
    assign p2_start   = {2'b00, p1_w} + {2'b00, delay};
    assign p2_end     = p2_start + {2'b00, p2_w};

    // Period counter; active registers only change at the wrap (or while stopped) so a
    // pulse window is never cut short by a mid-period write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            period    <= DEF_PERIOD;
            p1_w      <= DEF_P1_W;
            delay     <= DEF_DELAY;
            p2_w      <= DEF_P2_W;
            bus.Sync  <= 1'b0;
            bus.Pulse <= 1'b0;
            bus.P2    <= 1'b0;
        end else begin
            if (!run || wrap) begin
                cnt    <= '0;
                period <= sh_period;
                p1_w   <= sh_p1_w;
                delay  <= sh_delay;
                p2_w   <= sh_p2_w;
            end else begin
                cnt <= cnt + 32'd1;
            end
            bus.Sync  <= run && (cnt < SYNC_LIM);
            bus.Pulse <= run && (cnt < p1_w);
            bus.P2    <= run && (cnt_x >= p2_start) && (cnt_x < p2_end);
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t   rx_state;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_clk;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_vld;
    logic [7:0]  rx_byte;

    // Receiver: start confirmed at mid-bit, data and stop sampled at mid-bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state <= RX_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_vld   <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_s1   <= bus.RS232_Rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_vld  <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_clk   <= '0;
                    rx_state <= RX_START;
                end
                RX_START: if (rx_clk == HALF_LAST) begin
                    rx_clk   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_clk <= rx_clk + 16'd1;
                end
                RX_DATA: if (rx_clk == BIT_LAST) begin
                    rx_clk <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else begin
                    rx_clk <= rx_clk + 16'd1;
                end
                RX_STOP: if (rx_clk == BIT_LAST) begin
                    rx_clk   <= '0;
                    rx_state <= RX_IDLE;
                    if (rx_s2) begin
                        rx_vld  <= 1'b1;
                        rx_byte <= rx_sh;
                    end
                end else begin
                    rx_clk <= rx_clk + 16'd1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [2:0]  byte_idx;
    logic [7:0]  addr;
    logic [23:0] data_lo;
    logic [31:0] gap;
    logic [31:0] value;
    logic        ack_req;
    logic [7:0]  ack_byte;

    assign value = {rx_byte, data_lo};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_idx  <= '0;
            addr      <= '0;
            data_lo   <= '0;
            gap       <= '0;
            ack_req   <= 1'b0;
            ack_byte  <= '0;
            sh_period <= DEF_PERIOD;
            sh_p1_w   <= DEF_P1_W;
            sh_delay  <= DEF_DELAY;
            sh_p2_w   <= DEF_P2_W;
            run       <= 1'b1;
        end else begin
            ack_req <= 1'b0;
            if (rx_vld) begin
                gap <= '0;
                case (byte_idx)
                    3'd0: begin
                        addr     <= rx_byte;
                        byte_idx <= 3'd1;
                    end
                    3'd4: begin
                        byte_idx <= 3'd0;
                        ack_req  <= 1'b1;
                        ack_byte <= addr;
                        case (addr)
                            8'h01:   sh_period <= value;
                            8'h02:   sh_p1_w   <= value;
                            8'h03:   sh_delay  <= value;
                            8'h04:   sh_p2_w   <= value;
                            8'h05:   run       <= value[0];
                            default: ack_byte  <= 8'hFF;
                        endcase
                    end
                    default: begin
                        data_lo  <= {rx_byte, data_lo[23:8]};
                        byte_idx <= byte_idx + 3'd1;
                    end
                endcase
            end else if (byte_idx != 3'd0) begin
                // A stalled sender must not leave the parser out of step with the next frame.
                if (gap > GAP_MAX) begin
                    byte_idx <= '0;
                    gap      <= '0;
                end else begin
                    gap <= gap + 32'd1;
                end
            end
        end
    end

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    tx_state_t   tx_state;
    logic        pend_vld;
    logic [7:0]  pend_byte;
    logic [8:0]  tx_sh;
    logic [3:0]  tx_bit;
    logic [15:0] tx_clk;
    logic        tx_take;

    assign tx_take = (tx_state == TX_IDLE) && pend_vld;

    // One pending ack slot in front of the transmitter; acks arriving while it is full are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state     <= TX_IDLE;
            pend_vld     <= 1'b0;
            pend_byte    <= '0;
            tx_sh        <= '1;
            tx_bit       <= '0;
            tx_clk       <= '0;
            bus.RS232_Tx <= 1'b1;
        end else begin
            if (ack_req && (!pend_vld || tx_take)) begin
                pend_vld  <= 1'b1;
                pend_byte <= ack_byte;
            end else if (tx_take) begin
                pend_vld <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: if (pend_vld) begin
                    tx_sh        <= {1'b1, pend_byte};
                    tx_bit       <= '0;
                    tx_clk       <= '0;
                    bus.RS232_Tx <= 1'b0;
                    tx_state     <= TX_SEND;
                end
                TX_SEND: if (tx_clk == BIT_LAST) begin
                    tx_clk <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        bus.RS232_Tx <= tx_sh[0];
                        tx_sh        <= {1'b1, tx_sh[8:1]};
                        tx_bit       <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_clk <= tx_clk + 16'd1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_gen_ctrl.sv
// Directed bench for pulse_gen_ctrl: short UART bit time and a 500-clk default period.
module tb_pulse_gen_ctrl;
    localparam int CPB = 8;
    localparam int PER = 500;

    logic clk;
    logic resetn = 1'b1;
    int   checks;
    int   failures;
    int unsigned cyc;
    logic [7:0] ack_q[$];
    logic [7:0] mon_b;

    pulse_gen_ctrl_if bus();

    pulse_gen_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DEF_PERIOD  (PER),
        .DEF_P1_W    (30),
        .DEF_DELAY   (300),
        .DEF_P2_W    (60),
        .SYNC_W      (8)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release: after edge k the outputs reflect cnt = k-1.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Tx byte decoder; a frame with a bad stop bit is recorded as 8'hEE.
    initial begin
        forever begin
            @(negedge bus.RS232_Tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = bus.RS232_Tx;
            end
            repeat (CPB) @(negedge clk);
            if (bus.RS232_Tx === 1'b1) ack_q.push_back(mon_b);
            else                       ack_q.push_back(8'hEE);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_out(input longint unsigned c, input longint unsigned p1,
                                           input longint unsigned d, input longint unsigned p2);
        longint unsigned s;
        s = p1 + d;
        return {c < 64'd8, c < p1, (c >= s) && (c < s + p2)};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RS232_Rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] v);
        send_byte(a);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        send_byte(v[23:16]);
        send_byte(v[31:24]);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        ack_q.delete();
    endtask

    task automatic wait_acks(input int n);
        for (int i = 0; i < 400 && ack_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        bus.RS232_Rx = 1'b1;
        #1 resetn = 1'b0;
        repeat (5) @(negedge clk);
        got = {bus.Sync, bus.Pulse, bus.P2, bus.RS232_Tx};
        checks++;
        if (got !== 4'b0001) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0001", got);
        end
        resetn = 1'b1;
        ack_q.delete();
    endtask

    task automatic test_default_pattern();
        logic [2:0] got, exp;
        int unsigned k;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            k   = cyc;
            exp = exp_out((k - 1) % PER, 30, 300, 60);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL default_pattern k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_period_change();
        logic [2:0] got, exp;
        int unsigned k, c;
        do_reset();
        send_frame(8'h01, 32'd1000);
        while (cyc < 1600) begin
            @(negedge clk);
            k   = cyc;
            c   = (k <= 500) ? k - 1 : (k - 501) % 1000;
            exp = exp_out(c, 30, 300, 60);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL period_change k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        wait_acks(1);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 8'h01) begin
            failures++;
            $display("FAIL period_ack count=%0d byte=%h exp one 01", ack_q.size(), ack_q[0]);
        end
    endtask

    task automatic test_p1_zero();
        logic [2:0] got, exp;
        int unsigned k;
        do_reset();
        send_frame(8'h02, 32'd0);
        while (cyc < 1100) begin
            @(negedge clk);
            k   = cyc;
            exp = exp_out((k - 1) % PER, (k <= 500) ? 30 : 0, 300, 60);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL p1_zero k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        wait_acks(1);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 8'h02) begin
            failures++;
            $display("FAIL p1_zero_ack count=%0d byte=%h exp one 02", ack_q.size(), ack_q[0]);
        end
    endtask

    task automatic test_run_stop();
        logic [2:0] got, exp;
        do_reset();
        send_frame(8'h05, 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 600; i++) begin
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== 3'b000) begin
                failures++;
                $display("FAIL run_stop i=%0d got=%b exp=000", i, got);
            end
            @(negedge clk);
        end
        send_frame(8'h05, 32'd1);
        got = {bus.Sync, bus.Pulse, bus.P2};
        checks++;
        if (got !== 3'b000) begin
            failures++;
            $display("FAIL run_restart_edge got=%b exp=000", got);
        end
        for (int j = 1; j <= 600; j++) begin
            @(negedge clk);
            exp = exp_out((j - 1) % PER, 30, 300, 60);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL run_restart j=%0d got=%b exp=%b", j, got, exp);
            end
        end
        wait_acks(2);
        checks++;
        if (ack_q.size() != 2 || ack_q[0] !== 8'h05 || ack_q[1] !== 8'h05) begin
            failures++;
            $display("FAIL run_acks count=%0d first=%h second=%h exp 05 05",
                     ack_q.size(), ack_q[0], ack_q[1]);
        end
    endtask

    task automatic test_bad_addr_timeout();
        logic [2:0] got, exp;
        int unsigned k, kw;
        do_reset();
        send_frame(8'h09, 32'h1234_5678);
        wait_acks(1);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 8'hFF) begin
            failures++;
            $display("FAIL bad_addr_ack count=%0d byte=%h exp one FF", ack_q.size(), ack_q[0]);
        end
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (250) @(negedge clk);
        checks++;
        if (ack_q.size() != 1) begin
            failures++;
            $display("FAIL timeout_no_ack count=%0d exp 1", ack_q.size());
        end
        send_frame(8'h04, 32'd20);
        wait_acks(2);
        checks++;
        if (ack_q.size() != 2 || ack_q[1] !== 8'h04) begin
            failures++;
            $display("FAIL after_timeout_ack count=%0d byte=%h exp 04", ack_q.size(), ack_q[1]);
        end
        kw = ((cyc / PER) + 1) * PER;
        while (cyc < kw) @(negedge clk);
        for (int i = 0; i < PER + 20; i++) begin
            @(negedge clk);
            k   = cyc;
            exp = exp_out((k - 1) % PER, 30, 300, 20);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL p2_width k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        int unsigned k;
        do_reset();
        send_frame(8'h03, 32'd100);
        send_frame(8'h04, 32'd10);
        wait_acks(2);
        checks++;
        if (ack_q.size() != 2 || ack_q[0] !== 8'h03 || ack_q[1] !== 8'h04) begin
            failures++;
            $display("FAIL b2b_acks count=%0d first=%h second=%h exp 03 04",
                     ack_q.size(), ack_q[0], ack_q[1]);
        end
        while (cyc < 1000) @(negedge clk);
        while (cyc < 1520) begin
            @(negedge clk);
            k   = cyc;
            exp = exp_out((k - 1) % PER, 30, 100, 10);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_pattern k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] got, exp;
        logic [3:0] rst_got;
        int unsigned k;
        do_reset();
        send_frame(8'h01, 32'd200);
        wait_acks(1);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 8'h01) begin
            failures++;
            $display("FAIL pre_reset_ack count=%0d byte=%h exp one 01", ack_q.size(), ack_q[0]);
        end
        send_byte(8'h02);
        send_byte(8'h05);
        for (int i = 0; i < 600 && bus.Pulse !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.Pulse !== 1'b1) begin
            failures++;
            $display("FAIL pulse_before_reset got=%b exp=1", bus.Pulse);
        end
        #2 resetn = 1'b0;
        #1 rst_got = {bus.Sync, bus.Pulse, bus.P2, bus.RS232_Tx};
        checks++;
        if (rst_got !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0001", rst_got);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        ack_q.delete();
        send_frame(8'h03, 32'd300);
        wait_acks(1);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 8'h03) begin
            failures++;
            $display("FAIL post_reset_ack count=%0d byte=%h exp one 03", ack_q.size(), ack_q[0]);
        end
        while (cyc < 1100) begin
            @(negedge clk);
            k   = cyc;
            exp = exp_out((k - 1) % PER, 30, 300, 60);
            got = {bus.Sync, bus.Pulse, bus.P2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL defaults_restored k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_default_pattern();
        test_period_change();
        test_p1_zero();
        test_run_stop();
        test_bad_addr_timeout();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
